// File: rtl/i2s_audio_out.sv
// rtl/i2s_audio_out.sv - I2S stereo serializer with a fractional-accumulator BCK/LRCK generator
// Define I2S_MCLK_EN to add the 256*fs i2s_mclk output.
module i2s_audio_out #(
  parameter int CLK_RATE    = 50_000_000,
  parameter int SAMPLE_RATE = 48_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] left_in,
  input  logic [15:0] right_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        underrun,
  output logic        i2s_bck,
  output logic        i2s_lrck,
  output logic        i2s_data
`ifdef I2S_MCLK_EN
  ,
  output logic        i2s_mclk
`endif
);

  localparam logic [32:0] C_CLK     = 33'(CLK_RATE);
  localparam logic [32:0] C_BCK_INC = 33'(128 * SAMPLE_RATE);

  logic [31:0] r_acc;
  logic        r_bck;
  logic [5:0]  r_c;
  logic        r_lrck;
  logic        r_data;
  logic        r_underrun;
  logic [15:0] r_cur_l;
  logic [15:0] r_cur_r;
  logic        r_hold_full;
  logic [15:0] r_hold_l;
  logic [15:0] r_hold_r;

  logic [32:0] w_sum;
  logic        w_tick;
  logic        w_fall;
  logic        w_load;
  logic        w_accept;
  logic [5:0]  w_c_next;
  logic [3:0]  w_bitpos;
  logic        w_in_word;
  logic        w_bit;

  assign w_sum     = {1'b0, r_acc} + C_BCK_INC;
  assign w_tick    = (w_sum >= C_CLK);
  assign w_fall    = w_tick & r_bck;
  assign w_c_next  = r_c + 6'd1;
  assign w_load    = w_fall & (r_c == 6'd63);
  assign w_accept  = sample_valid & ~r_hold_full;

  // Slot s carries sample bit 16-s for s = 1..16; r_cur_* is already updated by slot 1.
  assign w_bitpos  = 4'(5'd16 - w_c_next[4:0]);
  assign w_in_word = (w_c_next[4:0] != 5'd0) && (w_c_next[4:0] <= 5'd16);
  assign w_bit     = w_c_next[5] ? r_cur_r[w_bitpos] : r_cur_l[w_bitpos];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_acc  <= 32'd0;
      r_bck  <= 1'b0;
      r_c    <= 6'd63;
      r_lrck <= 1'b0;
      r_data <= 1'b0;
    end else begin
      r_acc <= w_tick ? 32'(w_sum - C_CLK) : w_sum[31:0];
      if (w_tick) begin
        r_bck <= ~r_bck;
      end
      if (w_fall) begin
        r_c    <= w_c_next;
        r_lrck <= w_c_next[5];
        r_data <= w_in_word & w_bit;
      end
    end
  end

  // Load sees the pre-accept hold state; an empty hold repeats the last pair.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_underrun  <= 1'b0;
      r_cur_l     <= 16'd0;
      r_cur_r     <= 16'd0;
      r_hold_full <= 1'b0;
      r_hold_l    <= 16'd0;
      r_hold_r    <= 16'd0;
    end else begin
      r_underrun <= w_load & ~r_hold_full;
      if (w_load && r_hold_full) begin
        r_cur_l     <= r_hold_l;
        r_cur_r     <= r_hold_r;
        r_hold_full <= 1'b0;
      end else if (w_accept) begin
        r_hold_l    <= left_in;
        r_hold_r    <= right_in;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign sample_ready = ~r_hold_full;
  assign underrun     = r_underrun;
  assign i2s_bck      = r_bck;
  assign i2s_lrck     = r_lrck;
  assign i2s_data     = r_data;

`ifdef I2S_MCLK_EN
  localparam logic [32:0] C_MCLK_INC = 33'(512 * SAMPLE_RATE);

  logic [31:0] r_macc;
  logic        r_mclk;
  logic [32:0] w_msum;
  logic        w_mwrap;

  assign w_msum  = {1'b0, r_macc} + C_MCLK_INC;
  assign w_mwrap = (w_msum >= C_CLK);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_macc <= 32'd0;
      r_mclk <= 1'b0;
    end else begin
      r_macc <= w_mwrap ? 32'(w_msum - C_CLK) : w_msum[31:0];
      if (w_mwrap) begin
        r_mclk <= ~r_mclk;
      end
    end
  end

  assign i2s_mclk = r_mclk;
`endif

endmodule
